// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Defining FETCH_HALT_EN adds the HALT state and the 4'hF halt opcode.
package fetch_seq_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 8;

   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_LOOP = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      st_idle    = 3'd0,
      st_fetch   = 3'd1,
      st_capture = 3'd2,
      st_exec    = 3'd3,
      st_update  = 3'd4
`ifdef FETCH_HALT_EN
      ,
      st_halt    = 3'd5
`endif
   } state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Bus bundle between the fetch sequencer, the instruction ROM, the
// program counter and the execute stage.
interface fetch_seq_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          start;
   logic [AW-1:0] pc;
   logic [DW-1:0] mem_data;
   logic          ex_done;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          pc_inc;
   logic          pc_wen;
   logic          pc_rst;
   logic [AW-1:0] bus_out;

   modport master (
      input  start, pc, mem_data, ex_done,
      output mem_addr, mem_rd, ir, ir_valid, pc_inc, pc_wen, pc_rst, bus_out
   );

   modport slave (
      output start, pc, mem_data, ex_done,
      input  mem_addr, mem_rd, ir, ir_valid, pc_inc, pc_wen, pc_rst, bus_out
   );
endinterface

// File: rtl/fetch_seq_dec.sv
// Combinational opcode decoder: instruction word to counter control request.
// With FETCH_HALT_EN undefined, 4'hF decodes as an ordinary increment.
module fetch_dec
   import fetch_seq_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0] ir,
   output logic          inc,
   output logic          wen,
   output logic          rst,
   output logic          halt,
   output logic [AW-1:0] target
);
   logic [3:0] op;

   assign op     = ir[DW-1:DW-4];
   assign target = ir[AW-1:0];

   always_comb begin
      inc  = 1'b0;
      wen  = 1'b0;
      rst  = 1'b0;
      halt = 1'b0;
      case (op)
         OP_JMP:  wen = 1'b1;
         OP_LOOP: rst = 1'b1;
`ifdef FETCH_HALT_EN
         OP_HALT: halt = 1'b1;
`endif
         default: inc = 1'b1;
      endcase
   end
endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: FETCH/CAPTURE/EXEC/UPDATE loop driving one
// counter pulse per instruction. FETCH_HALT_EN enables the HALT opcode/state.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic       Clk,
   input  logic       RSTn,
   fetch_seq_if.master bus
);
   state_t        state, state_nxt;
   logic [DW-1:0] ir_q;
   logic          dec_inc, dec_wen, dec_rst, dec_halt;
   logic [AW-1:0] dec_target;
   logic          upd;

   fetch_dec #(.AW(AW), .DW(DW)) u_dec (
      .ir     (ir_q),
      .inc    (dec_inc),
      .wen    (dec_wen),
      .rst    (dec_rst),
      .halt   (dec_halt),
      .target (dec_target)
   );

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         state <= st_idle;
         ir_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == st_capture) ir_q <= bus.mem_data;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:    if (bus.start) state_nxt = st_fetch;
         st_fetch:   state_nxt = st_capture;
         st_capture: state_nxt = st_exec;
         st_exec:    if (bus.ex_done) state_nxt = st_update;
         st_update: begin
`ifdef FETCH_HALT_EN
            state_nxt = dec_halt ? st_halt : st_fetch;
`else
            state_nxt = st_fetch;
`endif
         end
`ifdef FETCH_HALT_EN
         st_halt:    if (bus.start) state_nxt = st_fetch;
`endif
         default:    state_nxt = st_idle;
      endcase
   end

   // Moore outputs: everything below decodes from the state register and ir.
   assign upd = (state == st_update) && !dec_halt;

   always_comb begin
      bus.mem_rd   = (state == st_fetch);
      bus.mem_addr = (state == st_fetch) ? bus.pc : '0;
      bus.ir_valid = (state == st_exec);
      bus.pc_inc   = upd && dec_inc;
      bus.pc_wen   = upd && dec_wen;
      bus.pc_rst   = upd && dec_rst;
      bus.bus_out  = (upd && dec_wen) ? dec_target : '0;
   end

   assign bus.ir = ir_q;
endmodule
